// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encodings,
// requester indices and memory strobe levels.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam logic MEM_STROBE_ON  = 1'b0;
  localparam logic MEM_STROBE_OFF = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters/memory (master side) and the arbiter
// (slave side).
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  // Handshake: req[i] is a level request; we/addr/wdata for requester i must
  // stay stable while req[i] is high. gnt[i] marks ownership from XFER
  // through RESP, done[i] pulses for one cycle in RESP (rdata valid then),
  // and the requester drops req[i] on the edge that ends RESP.
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          mem_R;
  logic          mem_W;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, done, rdata, mem_R, mem_W, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, done, rdata, mem_R, mem_W, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, on contention the
// requester that did not win last time gets the grant.
module mem_arbiter_rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       winner
);

  always_comb begin
    winner = REQ_CPU;
    if (req == 2'b11) begin
      winner = ~rr_last;
    end else if (req[REQ_DMA] && !req[REQ_CPU]) begin
      winner = REQ_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port system memory between the CPU (requester 0) and
// DMA (requester 1). Define MEM_ARB_FIXED_PRIO_EN for fixed CPU priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output arb_state_t    dbg_state
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          pick;
  logic          winner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [3:0]    wait_cnt;
  logic          start;

  logic [1:0]    gnt_d;
  logic [1:0]    done_d;
  logic          mem_r_d;
  logic          mem_w_d;

  assign start = (state == ST_IDLE) && (|bus.req);

`ifdef MEM_ARB_FIXED_PRIO_EN
  // CPU always wins when it asks; DMA only gets the memory when the CPU is quiet.
  assign pick = ~bus.req[REQ_CPU];
`else
  logic rr_last;

  mem_arbiter_rr_pick2 u_pick (
    .req     (bus.req),
    .rr_last (rr_last),
    .winner  (pick)
  );

  // Reset value makes the CPU the first contention winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= REQ_DMA;
    end else if (start) begin
      rr_last <= pick;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|bus.req) state_nxt = ST_XFER;
      ST_XFER: if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The request is captured once in IDLE; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q <= REQ_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= 4'd0;
    end else if (start) begin
      winner_q <= pick;
      we_q     <= bus.we[pick];
      addr_q   <= (pick == REQ_DMA) ? bus.addr1 : bus.addr0;
      wdata_q  <= (pick == REQ_DMA) ? bus.wdata1 : bus.wdata0;
      wait_cnt <= WAIT_LOAD;
    end else if (state == ST_XFER) begin
      if (wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end else if (!we_q) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    mem_r_d = MEM_STROBE_OFF;
    mem_w_d = MEM_STROBE_OFF;
    case (state)
      ST_XFER: begin
        gnt_d[winner_q] = 1'b1;
        if (we_q) mem_w_d = MEM_STROBE_ON;
        else      mem_r_d = MEM_STROBE_ON;
      end
      ST_RESP: begin
        gnt_d[winner_q]  = 1'b1;
        done_d[winner_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.gnt       = gnt_d;
  assign bus.done      = done_d;
  assign bus.mem_R     = mem_r_d;
  assign bus.mem_W     = mem_w_d;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: lane 0 runs WAIT_CYCLES=1, lane 1 runs WAIT_CYCLES=3,
// each with its own memory and a transaction-schedule reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       mr;
    logic       mw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rd_v;
    logic [7:0] rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rst_v   [2];
  logic [1:0] req_v   [2];
  logic [1:0] we_v    [2];
  logic [7:0] a0_v    [2];
  logic [7:0] a1_v    [2];
  logic [7:0] d0_v    [2];
  logic [7:0] d1_v    [2];
  logic [1:0] gnt_v   [2];
  logic [1:0] done_v  [2];
  logic [7:0] rdata_v [2];
  logic [7:0] maddr_v [2];
  logic [7:0] mwd_v   [2];
  logic       mr_v    [2];
  logic       mw_v    [2];
  arb_state_t st_v    [2];

  function automatic exp_t idle_e();
    exp_t e;
    e    = '0;
    e.mr = 1'b1;
    e.mw = 1'b1;
    return e;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(act === exp, name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WC = (g == 0) ? 1 : 3;

    mem_arbiter_if #(.AW(8), .DW(8)) bus ();
    arb_state_t st;
    logic       lrst;

    mem_arbiter #(.AW(8), .DW(8), .WAIT_CYCLES(WC)) dut (
      .clk       (clk),
      .rst       (lrst),
      .bus       (bus),
      .dbg_state (st)
    );

    assign lrst       = rst_v[g];
    assign bus.req    = req_v[g];
    assign bus.we     = we_v[g];
    assign bus.addr0  = a0_v[g];
    assign bus.addr1  = a1_v[g];
    assign bus.wdata0 = d0_v[g];
    assign bus.wdata1 = d1_v[g];
    assign gnt_v[g]   = bus.gnt;
    assign done_v[g]  = bus.done;
    assign rdata_v[g] = bus.rdata;
    assign maddr_v[g] = bus.mem_addr;
    assign mwd_v[g]   = bus.mem_wdata;
    assign mr_v[g]    = bus.mem_R;
    assign mw_v[g]    = bus.mem_W;
    assign st_v[g]    = st;

    // Memory model: combinational read while mem_R is low, write on posedge.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]     = 8'(i * 37 + 11) ^ 8'(g);
        ref_mem[i] = 8'(i * 37 + 11) ^ 8'(g);
      end
      mem[8'h05] = 8'hC1; ref_mem[8'h05] = 8'hC1;
      mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
    end

    assign bus.mem_rdata = (bus.mem_R == 1'b0) ? mem[bus.mem_addr] : 8'hEE;

    always @(posedge clk) begin
      if (bus.mem_W == 1'b0) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // Reference model: when idle and a request is seen, schedule the whole
    // access (WC strobe cycles then one response cycle) into exp_q.
    exp_t       exp_q [$];
    exp_t       cur;
    logic       m_last;
    logic [7:0] exp_rdata;

    always @(posedge clk or posedge lrst) begin : model
      exp_t       nxt;
      logic       win;
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
      if (lrst) begin
        exp_q.delete();
        cur       <= idle_e();
        m_last    <= 1'b1;
        exp_rdata <= 8'h00;
      end else begin
        if (exp_q.size() == 0 && cur.done == 2'b00 && req_v[g] != 2'b00) begin
          if (req_v[g] == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~m_last;
`endif
          end else begin
            win = (req_v[g] == 2'b10);
          end
          m_last <= win;
          wr = we_v[g][win];
          a  = win ? a1_v[g] : a0_v[g];
          d  = win ? d1_v[g] : d0_v[g];
          nxt       = idle_e();
          nxt.gnt   = win ? 2'b10 : 2'b01;
          nxt.mr    = wr;
          nxt.mw    = ~wr;
          nxt.addr  = a;
          nxt.wdata = d;
          repeat (WC) exp_q.push_back(nxt);
          nxt.mr   = 1'b1;
          nxt.mw   = 1'b1;
          nxt.done = nxt.gnt;
          nxt.rd_v = ~wr;
          nxt.rd   = ref_mem[a];
          exp_q.push_back(nxt);
          if (wr) ref_mem[a] = d;
        end
        if (exp_q.size() != 0) begin
          nxt = exp_q.pop_front();
          cur <= nxt;
          if (nxt.rd_v) exp_rdata <= nxt.rd;
        end else begin
          cur <= idle_e();
        end
      end
    end

    always @(negedge clk) begin : compare
      logic xf;
      if (!lrst) begin
        xf = !cur.mr || !cur.mw;
        check((bus.gnt === cur.gnt) && (bus.done === cur.done) &&
              (bus.mem_R === cur.mr) && (bus.mem_W === cur.mw) &&
              (bus.rdata === exp_rdata) &&
              (!xf || (bus.mem_addr === cur.addr && bus.mem_wdata === cur.wdata)),
              (g == 0) ? "lane0_cycle" : "lane1_cycle",
              32'({bus.gnt, bus.done, bus.mem_R, bus.mem_W, bus.rdata, bus.mem_addr, bus.mem_wdata}),
              32'({cur.gnt, cur.done, cur.mr, cur.mw, exp_rdata, cur.addr, cur.wdata}));
        check(!(bus.mem_R == 1'b0 && bus.mem_W == 1'b0), "strobe_excl",
              32'({bus.mem_R, bus.mem_W}), 32'h3);
      end
    end
  end

  task automatic drive(input int ln, input logic [1:0] r, input logic [1:0] w,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req_v[ln] = r;
    we_v[ln]  = w;
    a0_v[ln]  = a0;
    a1_v[ln]  = a1;
    d0_v[ln]  = d0;
    d1_v[ln]  = d1;
  endtask

  task automatic wait_done(input int ln, output logic [1:0] who);
    who = 2'b00;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (done_v[ln] != 2'b00) begin
        who = done_v[ln];
        break;
      end
    end
    if (who == 2'b00) check(1'b0, "done_timeout", 32'(who), 32'h1);
  endtask

  initial begin : stim
    logic [1:0] who;
    logic [1:0] ord [4];
    int         lowcnt;
    int         lat;

    for (int l = 0; l < 2; l++) begin
      rst_v[l] = 1'b1;
      drive(l, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    end
    repeat (3) @(negedge clk);

    check_eq("rst_gnt",   32'(gnt_v[0]),   32'h0);
    check_eq("rst_done",  32'(done_v[0]),  32'h0);
    check_eq("rst_rdata", 32'(rdata_v[0]), 32'h0);
    check_eq("rst_mem_R", 32'(mr_v[0]),    32'h1);
    check_eq("rst_mem_W", 32'(mw_v[0]),    32'h1);
    check_eq("rst_maddr", 32'(maddr_v[0]), 32'h0);
    check_eq("rst_mwdat", 32'(mwd_v[0]),   32'h0);
    check_eq("rst_state", 32'(st_v[0]),    32'(ST_IDLE));
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // Single read by requester 0.
    @(negedge clk);
    drive(0, 2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check_eq("rd_gnt",   32'(gnt_v[0]),   32'h1);
    check_eq("rd_mem_R", 32'(mr_v[0]),    32'h0);
    check_eq("rd_maddr", 32'(maddr_v[0]), 32'h05);
    @(negedge clk);
    check_eq("rd_done",  32'(done_v[0]),  32'h1);
    check_eq("rd_rdata", 32'(rdata_v[0]), 32'hC1);
    check_eq("rd_mem_R_off", 32'(mr_v[0]), 32'h1);
    drive(0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check_eq("rd_done_pulse", 32'(done_v[0]), 32'h0);
    check_eq("rd_gnt_off",    32'(gnt_v[0]),  32'h0);

    // Single write by requester 1, then read it back through requester 0.
    drive(0, 2'b10, 2'b10, 8'h00, 8'h07, 8'h00, 8'h0A);
    @(negedge clk);
    check_eq("wr_mem_W", 32'(mw_v[0]),    32'h0);
    check_eq("wr_mem_R", 32'(mr_v[0]),    32'h1);
    check_eq("wr_maddr", 32'(maddr_v[0]), 32'h07);
    check_eq("wr_mwdat", 32'(mwd_v[0]),   32'h0A);
    check_eq("wr_gnt",   32'(gnt_v[0]),   32'h2);
    @(negedge clk);
    check_eq("wr_done",  32'(done_v[0]),  32'h2);
    check_eq("wr_rdata_held", 32'(rdata_v[0]), 32'hC1);
    drive(0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check_eq("wr_mem_07", 32'(lane[0].mem[8'h07]), 32'h0A);
    drive(0, 2'b01, 2'b00, 8'h07, 8'h00, 8'h00, 8'h00);
    wait_done(0, who);
    check_eq("rb_rdata", 32'(rdata_v[0]), 32'h0A);
    drive(0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Contention after reset.
`ifdef MEM_ARB_FIXED_PRIO_EN
    ord[0] = 2'b01; ord[1] = 2'b01; ord[2] = 2'b01; ord[3] = 2'b01;
`else
    ord[0] = 2'b01; ord[1] = 2'b10; ord[2] = 2'b01; ord[3] = 2'b10;
`endif
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 2'b11, 2'b00, 8'(8'h30 + k), 8'(8'h40 + k), 8'h00, 8'h00);
      wait_done(0, who);
      check_eq("contention_order", 32'(who), 32'(ord[k]));
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    end

    // Wait states on lane 1 (WAIT_CYCLES = 3).
    @(negedge clk);
    drive(1, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    lowcnt = 0;
    lat    = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mr_v[1] == 1'b0) lowcnt++;
      if (done_v[1] != 2'b00) begin
        lat = i;
        break;
      end
    end
    drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_eq("ws_strobe_cycles", 32'(lowcnt), 32'd3);
    check_eq("ws_latency",       32'(lat),    32'd4);
    check_eq("ws_rdata",         32'(rdata_v[1]), 32'h5A);

    // Reset in the second of three XFER cycles.
    @(negedge clk);
    drive(1, 2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_v[1] = 1'b1;
    #1;
    check_eq("mid_rst_mem_R", 32'(mr_v[1]),  32'h1);
    check_eq("mid_rst_gnt",   32'(gnt_v[1]), 32'h0);
    check_eq("mid_rst_state", 32'(st_v[1]),  32'(ST_IDLE));
    drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) begin
      @(negedge clk);
      check_eq("mid_rst_no_done", 32'(done_v[1]), 32'h0);
    end
    rst_v[1] = 1'b0;
    drive(1, 2'b11, 2'b00, 8'h21, 8'h22, 8'h00, 8'h00);
    wait_done(1, who);
    check_eq("post_rst_first_gnt", 32'(who), 32'h1);
    drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Random traffic on lane 0; the per-cycle model and exclusivity checks run throughout.
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      drive(0, 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_done(0, who);
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
